// File: rtl/expr_eval.sv
// Streaming evaluator for digit ((+|*) digit)* with '*' binding tighter than '+'.
// One ASCII character per clock; result/ok/err update on the edge that samples it.
module expr_eval (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  in,
    output logic [31:0] result = '0,
    output logic        ok     = 1'b0,
    output logic        err    = 1'b0
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NUM  = 2'd1;
    localparam logic [1:0] OP   = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]  state = IDLE;
    logic [31:0] sum   = '0;
    logic [31:0] term  = '0;
    logic        mul   = 1'b0;

    logic        is_digit;
    logic        is_plus;
    logic        is_star;
    logic        is_op;
    logic [31:0] dval;
    logic [31:0] new_term;
    logic        to_err;

    always_comb begin
        is_digit = (in >= 8'h30) && (in <= 8'h39);
        is_plus  = (in == 8'h2b);
        is_star  = (in == 8'h2a);
        is_op    = is_plus || is_star;
        dval     = {24'd0, in - 8'h30};
        // Products wrap modulo 2^32; overflow is not an error.
        new_term = mul ? term * dval : dval;
        to_err   = ((state == IDLE) && is_op) ||
                   ((state == NUM)  && is_digit) ||
                   ((state == OP)   && is_op);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            sum    <= '0;
            term   <= '0;
            mul    <= 1'b0;
            result <= '0;
            ok     <= 1'b0;
            err    <= 1'b0;
        end else if (to_err) begin
            state  <= ERR;
            result <= '0;
            ok     <= 1'b0;
            err    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        term   <= dval;
                        result <= sum + dval;
                        ok     <= 1'b1;
                        state  <= NUM;
                    end
                end
                NUM: begin
                    if (is_plus) begin
                        sum   <= sum + term;
                        mul   <= 1'b0;
                        ok    <= 1'b0;
                        state <= OP;
                    end else if (is_star) begin
                        mul   <= 1'b1;
                        ok    <= 1'b0;
                        state <= OP;
                    end
                end
                OP: begin
                    if (is_digit) begin
                        term   <= new_term;
                        result <= sum + new_term;
                        ok     <= 1'b1;
                        state  <= NUM;
                    end
                end
                default: ;  // ERR absorbs everything until clr
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval: one character per cycle, outputs checked
// one time unit after the sampling edge against hand-computed values.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in  = 8'h00;
    logic [31:0] result;
    logic        ok;
    logic        err;

    int checks   = 0;
    int failures = 0;

    expr_eval dut (
        .clk    (clk),
        .clr    (clr),
        .in     (in),
        .result (result),
        .ok     (ok),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] er, input logic eo,
                              input logic ee);
        check({tag, ".result"}, result, er);
        check({tag, ".ok"}, {31'd0, ok}, {31'd0, eo});
        check({tag, ".err"}, {31'd0, err}, {31'd0, ee});
    endtask

    task automatic send(input string tag, input logic [7:0] c, input logic [31:0] er,
                        input logic eo, input logic ee);
        in = c;
        @(posedge clk);
        #1;
        expect_out(tag, er, eo, ee);
    endtask

    task automatic do_reset(input string tag, input logic [7:0] c);
        clr = 1'b1;
        in  = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in  = 8'h00;
        expect_out(tag, 32'd0, 1'b0, 1'b0);
    endtask

    logic [31:0] prod;

    initial begin
        #1;
        expect_out("powerup", 32'd0, 1'b0, 1'b0);

        do_reset("rst0", 8'h35);

        // 2+3*4
        send("a1", "2", 32'd2, 1'b1, 1'b0);
        send("a2", "+", 32'd2, 1'b0, 1'b0);
        send("a3", "3", 32'd5, 1'b1, 1'b0);
        send("a4", "*", 32'd5, 1'b0, 1'b0);
        send("a5", "4", 32'd14, 1'b1, 1'b0);

        // 2*3+4*5 = 26
        do_reset("rst1", 8'h00);
        send("p1", "2", 32'd2, 1'b1, 1'b0);
        send("p2", "*", 32'd2, 1'b0, 1'b0);
        send("p3", "3", 32'd6, 1'b1, 1'b0);
        send("p4", "+", 32'd6, 1'b0, 1'b0);
        send("p5", "4", 32'd10, 1'b1, 1'b0);
        send("p6", "*", 32'd10, 1'b0, 1'b0);
        send("p7", "5", 32'd26, 1'b1, 1'b0);

        // 9*9*9*9
        do_reset("rst2", 8'h00);
        send("b1", "9", 32'd9, 1'b1, 1'b0);
        send("b2", "*", 32'd9, 1'b0, 1'b0);
        send("b3", "9", 32'd81, 1'b1, 1'b0);
        send("b4", "*", 32'd81, 1'b0, 1'b0);
        send("b5", "9", 32'd729, 1'b1, 1'b0);
        send("b6", "*", 32'd729, 1'b0, 1'b0);
        send("b7", "9", 32'd6561, 1'b1, 1'b0);

        // Eleven 9s: wraps modulo 2^32 without flagging err
        do_reset("rst3", 8'h00);
        prod = 32'd9;
        send("w0", "9", prod, 1'b1, 1'b0);
        for (int i = 1; i < 11; i++) begin
            send("wop", "*", prod, 1'b0, 1'b0);
            prod = prod * 32'd9;
            send("wdig", "9", prod, 1'b1, 1'b0);
        end
        check("w.final", result, 32'd1316288537);

        // 1++ then 5
        do_reset("rst4", 8'h00);
        send("c1", "1", 32'd1, 1'b1, 1'b0);
        send("c2", "+", 32'd1, 1'b0, 1'b0);
        send("c3", "+", 32'd0, 1'b0, 1'b1);
        send("c4", "5", 32'd0, 1'b0, 1'b1);

        // Two digits in a row; reset clears ERR
        do_reset("rst5", 8'h00);
        send("d1", "1", 32'd1, 1'b1, 1'b0);
        send("d2", "2", 32'd0, 1'b0, 1'b1);
        do_reset("rst6", 8'h00);
        send("d3", "*", 32'd0, 1'b0, 1'b1);
        send("d4", "+", 32'd0, 1'b0, 1'b1);

        // Reset mid-expression ignores the character on the clr edge
        do_reset("rst7", 8'h00);
        send("e1", "5", 32'd5, 1'b1, 1'b0);
        send("e2", "*", 32'd5, 1'b0, 1'b0);
        do_reset("e3", "7");
        send("e4", "3", 32'd3, 1'b1, 1'b0);

        // Other characters are ignored in every state
        do_reset("rst8", 8'h00);
        send("f0", " ", 32'd0, 1'b0, 1'b0);
        send("f1", "4", 32'd4, 1'b1, 1'b0);
        send("f2", " ", 32'd4, 1'b1, 1'b0);
        send("f3", "+", 32'd4, 1'b0, 1'b0);
        send("f4", 8'h00, 32'd4, 1'b0, 1'b0);
        send("f5", "5", 32'd9, 1'b1, 1'b0);
        send("f6", "a", 32'd9, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
